lisa_qspi_arbiter: RTL

Shares one lisa_qqspi controller between NUM_REQ requesters, for example instruction fetch, data load/store and the debug port. The arbiter grants one requester at a time using round-robin and locks the grant until the SPI burst completes. While granted, it muxes that requester's command onto the controller and routes ready, rdata and done back to it. It also sequences the controller's valid/ready release protocol, so that no burst is issued before the controller has returned to idle.

---
 rtl/lisa_qspi_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lisa_qspi_arbiter.sv
// Round-robin arbiter sharing one lisa_qqspi controller among NUM_REQ requesters.
// The grant is locked for a whole burst and released only once the controller is idle again.
module lisa_qspi_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned CHIP_SELECTS = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*24-1:0]             req_addr,
    input  logic [NUM_REQ*16-1:0]             req_wdata,
    input  logic [NUM_REQ*2-1:0]              req_wstrb,
    input  logic [NUM_REQ*4-1:0]              req_xfer_len,
    input  logic [NUM_REQ*CHIP_SELECTS-1:0]   req_ce,
    input  logic [NUM_REQ-1:0]                req_ready_ack,
    output logic [NUM_REQ-1:0]                req_gnt,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                req_done,
    output logic [15:0]                       rdata,
    output logic                              spi_valid,
    output logic [23:0]                       spi_addr,
    output logic [15:0]                       spi_wdata,
    output logic [1:0]                        spi_wstrb,
    output logic [3:0]                        spi_xfer_len,
    output logic [CHIP_SELECTS-1:0]           spi_ce_ctrl,
    output logic                              spi_ready_ack,
    input  logic                              spi_ready,
    input  logic                              spi_xfer_done,
    input  logic [15:0]                       spi_rdata
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StRelease
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   last_q, last_d;

    logic [IDX_W-1:0]   winner;
    logic               found;

    // First requesting index after the last winner, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(last_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                // A ready still high from the previous burst means the controller is not idle yet.
                if (found && !spi_ready) begin
                    gnt_d         = '0;
                    gnt_d[winner] = 1'b1;
                    valid_d       = 1'b1;
                    last_d        = winner;
                    state_d       = StBusy;
                end
            end
            StBusy: begin
                if (spi_xfer_done) begin
                    valid_d = 1'b0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!spi_ready) begin
                    gnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= LAST_INIT;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Grant is zero or one-hot, so an OR of gated slices is a mux that idles at zero.
    always_comb begin
        spi_addr      = '0;
        spi_wdata     = '0;
        spi_wstrb     = '0;
        spi_xfer_len  = '0;
        spi_ce_ctrl   = '0;
        spi_ready_ack = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                spi_addr      = spi_addr | req_addr[24*i +: 24];
                spi_wdata     = spi_wdata | req_wdata[16*i +: 16];
                spi_wstrb     = spi_wstrb | req_wstrb[2*i +: 2];
                spi_xfer_len  = spi_xfer_len | req_xfer_len[4*i +: 4];
                spi_ce_ctrl   = spi_ce_ctrl | req_ce[CHIP_SELECTS*i +: CHIP_SELECTS];
                spi_ready_ack = spi_ready_ack | req_ready_ack[i];
            end
        end
    end

    assign req_gnt   = gnt_q;
    assign spi_valid = valid_q;
    assign req_ready = gnt_q & {NUM_REQ{spi_ready}};
    assign req_done  = gnt_q & {NUM_REQ{spi_xfer_done}};
    assign rdata     = spi_rdata;

endmodule
